// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI burst RAM slave.
//   cmd_t   : 2-bit frame command field (din[DATA_W+1:DATA_W])
//   state_t : top-level control FSM state
package spi_ram_pkg;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD      = 2'b11
   } cmd_t;

   typedef enum logic {
      ST_IDLE,
      ST_BURST
   } state_t;

endpackage

// File: rtl/spi_ram_mem.sv
// Word RAM with one synchronous write port and one synchronous read port.
// Contents and read register are not reset.
//   clk   : clock
//   we    : write enable, mem[waddr] <= wdata
//   waddr : write address (always < MEM_DEPTH)
//   wdata : write data
//   re    : read enable, rdata <= mem[raddr]; rdata holds while re is low
//   raddr : read address (always < MEM_DEPTH)
//   rdata : registered read data
module spi_ram_mem #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [MEM_DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// Command-driven RAM slave behind the SPI slave frame interface, with
// auto-incrementing pointers and multi-word burst reads over ready/valid.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   din      : frame {cmd[1:0], payload[DATA_W-1:0]}
//   rx_valid : din valid this cycle
//   busy     : read burst in progress; frames presented now are dropped
//   dout     : read data
//   tx_valid : dout valid
//   tx_ready : downstream accepts dout
module spi_ram_burst
   import spi_ram_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned AUTO_INC  = 1,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] din,
   input  logic              rx_valid,
   output logic              busy,
   output logic [DATA_W-1:0] dout,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam int unsigned CntW = $clog2(MAX_BURST + 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                tx_valid_q, tx_valid_d;
   // Set once the RAM read register holds a real word; gates dout to 0 after reset.
   logic                dout_live_q, dout_live_d;

   cmd_t                cmd;
   logic [DATA_W-1:0]   payload;
   logic [63:0]         pay_ext;
   logic [CntW-1:0]     burst_len;
   logic                xfer;

   logic                mem_we, mem_re;
   logic [ADDR_W-1:0]   mem_raddr;
   logic [DATA_W-1:0]   mem_rdata;

   assign cmd     = cmd_t'(din[DATA_W+1:DATA_W]);
   assign payload = din[DATA_W-1:0];
   assign pay_ext = 64'(payload);
   assign xfer    = tx_valid_q && tx_ready;

   function automatic logic [ADDR_W-1:0] load_addr(input logic [ADDR_W-1:0] a);
      return ADDR_W'(32'(a) % MEM_DEPTH);
   endfunction

   function automatic logic [ADDR_W-1:0] inc_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_W'(MEM_DEPTH - 1)) ? '0 : a + ADDR_W'(1);
   endfunction

   always_comb begin
      if (AUTO_INC == 0) begin
         burst_len = CntW'(1);
      end else if (pay_ext >= 64'(MAX_BURST - 1)) begin
         burst_len = CntW'(MAX_BURST);
      end else begin
         burst_len = CntW'(pay_ext) + CntW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      tx_valid_d  = tx_valid_q;
      dout_live_d = dout_live_q;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      mem_raddr   = rd_ptr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               unique case (cmd)
                  CMD_WR_ADDR: wr_ptr_d = load_addr(payload[ADDR_W-1:0]);
                  CMD_WR_DATA: begin
                     mem_we = 1'b1;
                     if (AUTO_INC != 0) wr_ptr_d = inc_addr(wr_ptr_q);
                  end
                  CMD_RD_ADDR: rd_ptr_d = load_addr(payload[ADDR_W-1:0]);
                  CMD_RD: begin
                     // Launch the first read now so the word is valid next cycle.
                     mem_re      = 1'b1;
                     cnt_d       = burst_len;
                     state_d     = ST_BURST;
                     busy_d      = 1'b1;
                     tx_valid_d  = 1'b1;
                     dout_live_d = 1'b1;
                  end
               endcase
            end
         end
         ST_BURST: begin
            // rd_ptr tracks the word on dout; on a transfer prefetch the next one.
            // Without a transfer re stays low, so the read register holds dout.
            if (xfer) begin
               if (AUTO_INC != 0) rd_ptr_d = inc_addr(rd_ptr_q);
               if (cnt_q > CntW'(1)) begin
                  mem_re    = 1'b1;
                  mem_raddr = inc_addr(rd_ptr_q);
                  cnt_d     = cnt_q - CntW'(1);
               end else begin
                  cnt_d      = '0;
                  state_d    = ST_IDLE;
                  busy_d     = 1'b0;
                  tx_valid_d = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         tx_valid_q  <= 1'b0;
         dout_live_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         tx_valid_q  <= tx_valid_d;
         dout_live_q <= dout_live_d;
      end
   end

   spi_ram_mem #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (payload),
      .re    (mem_re),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   assign busy     = busy_q;
   assign tx_valid = tx_valid_q;
   assign dout     = dout_live_q ? mem_rdata : '0;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: u_dut1 uses the defaults, u_dut2 has AUTO_INC=0 and
// a non-power-of-two depth. Both see the same frame stream and tx_ready.
module tb_spi_ram_burst;

   logic       clk;
   logic       rst_n;
   logic [9:0] din;
   logic       rx_valid;
   logic       tx_ready;
   logic       busy1, tv1, busy2, tv2;
   logic [7:0] dout1, dout2;

   int errors = 0;
   int checks = 0;

   int         xfer1 = 0;
   int         xfer2 = 0;
   int         busy_cyc1 = 0;
   logic [7:0] q1[$];

   spi_ram_burst #(
      .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1), .MAX_BURST(16)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .busy(busy1),
      .dout(dout1), .tx_valid(tv1), .tx_ready(tx_ready)
   );

   spi_ram_burst #(
      .DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(0), .MAX_BURST(16)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .busy(busy2),
      .dout(dout2), .tx_valid(tv2), .tx_ready(tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transfer monitor: samples just before the edge, i.e. the values the edge sees.
   always @(posedge clk) begin
      if (rst_n) begin
         if (tv1 && tx_ready) begin
            xfer1 <= xfer1 + 1;
            q1.push_back(dout1);
         end
         if (tv2 && tx_ready) xfer2 <= xfer2 + 1;
         if (busy1) busy_cyc1 <= busy_cyc1 + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1);
   end

   typedef struct {
      logic       rxv;
      logic [1:0] cmd;
      logic [7:0] pay;
      logic       exp_tv;
      logic       exp_busy;
      logic [7:0] exp_dout;
   } vec_t;

   vec_t tbl[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] c, input logic [7:0] p);
      din      = {c, p};
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while ((busy1 || busy2) && n < max) begin
         tick();
         n++;
      end
      check("idle_bound", 32'(busy1 | busy2), 32'd0);
   endtask

   initial begin
      int b1, b2, bb, base;

      // Frame sequence with tx_ready held high; rows 9 is sent while busy.
      tbl[0]  = '{1'b1, 2'b00, 8'h05, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 2'b01, 8'hAA, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 2'b01, 8'hBB, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{1'b1, 2'b01, 8'hC7, 1'b0, 1'b0, 8'h00};
      tbl[4]  = '{1'b1, 2'b10, 8'h05, 1'b0, 1'b0, 8'h00};
      tbl[5]  = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'hAA};
      tbl[6]  = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'hAA};
      tbl[7]  = '{1'b1, 2'b10, 8'h06, 1'b0, 1'b0, 8'hAA};
      tbl[8]  = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'hBB};
      tbl[9]  = '{1'b1, 2'b01, 8'h99, 1'b0, 1'b0, 8'hBB};
      tbl[10] = '{1'b1, 2'b10, 8'h07, 1'b0, 1'b0, 8'hBB};
      tbl[11] = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'hC7};
      tbl[12] = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'hC7};
      tbl[13] = '{1'b1, 2'b01, 8'h5A, 1'b0, 1'b0, 8'hC7};
      tbl[14] = '{1'b1, 2'b10, 8'h08, 1'b0, 1'b0, 8'hC7};
      tbl[15] = '{1'b1, 2'b11, 8'h00, 1'b1, 1'b1, 8'h5A};
      tbl[16] = '{1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h5A};

      rst_n    = 1'b0;
      din      = '0;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      #12;
      check("rst_dout", 32'(dout1), 32'h0);
      check("rst_tx_valid", 32'(tv1), 32'h0);
      check("rst_busy", 32'(busy1), 32'h0);
      check("rst_tx_valid2", 32'(tv2), 32'h0);
      rst_n = 1'b1;
      tick();

      // Writes, single reads, dropped frame, wr_ptr continuity.
      for (int i = 0; i < 17; i++) begin
         din      = {tbl[i].cmd, tbl[i].pay};
         rx_valid = tbl[i].rxv;
         tick();
         rx_valid = 1'b0;
         check($sformatf("tbl%0d_tx_valid", i), 32'(tv1), 32'(tbl[i].exp_tv));
         check($sformatf("tbl%0d_busy", i), 32'(busy1), 32'(tbl[i].exp_busy));
         check($sformatf("tbl%0d_dout", i), 32'(dout1), 32'(tbl[i].exp_dout));
      end

      // Two-word burst with a three-cycle stall on the first word.
      send(2'b10, 8'h05);
      b1       = xfer1;
      tx_ready = 1'b0;
      send(2'b11, 8'h01);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall%0d_tx_valid", i), 32'(tv1), 32'h1);
         check($sformatf("stall%0d_dout", i), 32'(dout1), 32'hAA);
         check($sformatf("stall%0d_busy", i), 32'(busy1), 32'h1);
         if (i < 2) tick();
      end
      tx_ready = 1'b1;
      tick();
      check("stall_w2_dout", 32'(dout1), 32'hBB);
      check("stall_w2_tx_valid", 32'(tv1), 32'h1);
      tick();
      check("stall_end_busy", 32'(busy1), 32'h0);
      check("stall_end_tx_valid", 32'(tv1), 32'h0);
      check("stall_end_dout", 32'(dout1), 32'hBB);
      check("stall_xfers", 32'(xfer1 - b1), 32'd2);
      wait_idle(20);

      // Wrap of wr_ptr and rd_ptr; a write sent mid-burst must be dropped.
      send(2'b00, 8'hFF);
      send(2'b01, 8'hCC);
      send(2'b01, 8'hDD);
      send(2'b10, 8'hFF);
      base = q1.size();
      send(2'b11, 8'h01);
      send(2'b01, 8'hEE);
      wait_idle(20);
      check("wrap_count", 32'(q1.size() - base), 32'd2);
      if (q1.size() >= base + 2) begin
         check("wrap_w0", 32'(q1[base]), 32'hCC);
         check("wrap_w1", 32'(q1[base+1]), 32'hDD);
      end
      send(2'b01, 8'h55);
      send(2'b10, 8'h00);
      base = q1.size();
      send(2'b11, 8'h01);
      wait_idle(20);
      check("drop_count", 32'(q1.size() - base), 32'd2);
      if (q1.size() >= base + 2) begin
         check("drop_w0", 32'(q1[base]), 32'hDD);
         check("drop_w1", 32'(q1[base+1]), 32'h55);
      end

      // Burst length clamp; AUTO_INC=0 instance always does a single word.
      b1 = xfer1;
      b2 = xfer2;
      bb = busy_cyc1;
      send(2'b11, 8'hFF);
      wait_idle(100);
      tick();
      check("clamp_xfers", 32'(xfer1 - b1), 32'd16);
      check("clamp_busy_cycles", 32'(busy_cyc1 - bb), 32'd16);
      check("noinc_xfers", 32'(xfer2 - b2), 32'd1);

      // Asynchronous reset during the third word of an eight-word burst.
      send(2'b00, 8'h10);
      for (int i = 0; i < 8; i++) send(2'b01, 8'(8'h80 + i));
      send(2'b10, 8'h10);
      send(2'b11, 8'h07);
      check("rb_w0", 32'(dout1), 32'h80);
      tick();
      tick();
      check("rb_w2", 32'(dout1), 32'h82);
      #2 rst_n = 1'b0;
      #1;
      check("rb_dout", 32'(dout1), 32'h0);
      check("rb_tx_valid", 32'(tv1), 32'h0);
      check("rb_busy", 32'(busy1), 32'h0);
      #2 rst_n = 1'b1;
      tick();
      send(2'b11, 8'h00);
      check("rb_read0_tv", 32'(tv1), 32'h1);
      check("rb_read0_dout", 32'(dout1), 32'hDD);
      wait_idle(20);

      // Out-of-range address reduced modulo depth (210 % 200 = 10).
      send(2'b00, 8'hD2);
      send(2'b01, 8'h77);
      send(2'b10, 8'hD2);
      send(2'b11, 8'h00);
      check("mod_tv", 32'(tv2), 32'h1);
      check("mod_dout", 32'(dout2), 32'h77);
      wait_idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
